// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-requester arbiter onto a single read-first RAM port (option: RAM_PORT_ARBITER_ROUND_ROBIN_EN)
module ram_port_arbiter #(
    parameter int ADDRESS_BITWIDTH     = 16,
    parameter int DATA_BITWIDTH        = 32,
    parameter int DATA_COLUMN_BITWIDTH = 8
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            m0_valid,
    output logic                                            m0_ready,
    input  logic [ADDRESS_BITWIDTH-1:0]                     m0_address,
    input  logic [DATA_BITWIDTH/DATA_COLUMN_BITWIDTH-1:0]   m0_write_enable,
    input  logic [DATA_BITWIDTH-1:0]                        m0_data_in,
    output logic                                            m0_rsp_valid,
    output logic [DATA_BITWIDTH-1:0]                        m0_data_out,
    input  logic                                            m1_valid,
    output logic                                            m1_ready,
    input  logic [ADDRESS_BITWIDTH-1:0]                     m1_address,
    input  logic [DATA_BITWIDTH/DATA_COLUMN_BITWIDTH-1:0]   m1_write_enable,
    input  logic [DATA_BITWIDTH-1:0]                        m1_data_in,
    output logic                                            m1_rsp_valid,
    output logic [DATA_BITWIDTH-1:0]                        m1_data_out,
    output logic [DATA_BITWIDTH/DATA_COLUMN_BITWIDTH-1:0]   ram_write_enable,
    output logic [ADDRESS_BITWIDTH-1:0]                     ram_address,
    output logic [DATA_BITWIDTH-1:0]                        ram_data_in,
    input  logic [DATA_BITWIDTH-1:0]                        ram_data_out
);

    localparam int COLUMNS = DATA_BITWIDTH / DATA_COLUMN_BITWIDTH;

    logic                        grant0;
    logic                        grant1;
    logic                        s1_valid_q;
    logic                        s1_owner_q;
    logic                        s2_valid_q;
    logic                        s2_owner_q;
    logic [COLUMNS-1:0]          ram_we_q;
    logic [ADDRESS_BITWIDTH-1:0] ram_addr_q;
    logic [DATA_BITWIDTH-1:0]    ram_wdata_q;
    logic [DATA_BITWIDTH-1:0]    hold0_q;
    logic [DATA_BITWIDTH-1:0]    hold1_q;

`ifdef RAM_PORT_ARBITER_ROUND_ROBIN_EN
    logic ptr_q;
    logic ptr_d;

    // Grant: preferred requester wins a tie; pointer moves on only when the preferred one is served.
    always_comb begin
        grant0 = rst_n && m0_valid && (!m1_valid || !ptr_q);
        grant1 = rst_n && m1_valid && !grant0;
        ptr_d  = ptr_q;
        if (grant0 && !ptr_q) begin
            ptr_d = 1'b1;
        end else if (grant1 && ptr_q) begin
            ptr_d = 1'b0;
        end
    end

    // Priority pointer register, starts preferring requester 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Grant: fixed priority, requester 0 always wins.
    always_comb begin
        grant0 = rst_n && m0_valid;
        grant1 = rst_n && m1_valid && !m0_valid;
    end
`endif

    assign m0_ready = grant0;
    assign m1_ready = grant1;

    // Stage 1: capture the granted request; it drives the RAM port during the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_owner_q  <= 1'b0;
            ram_we_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else if (grant0 || grant1) begin
            s1_valid_q  <= 1'b1;
            s1_owner_q  <= grant1;
            ram_we_q    <= grant1 ? m1_write_enable : m0_write_enable;
            ram_addr_q  <= grant1 ? m1_address      : m0_address;
            ram_wdata_q <= grant1 ? m1_data_in      : m0_data_in;
        end else begin
            s1_valid_q  <= 1'b0;
            ram_we_q    <= '0;
        end
    end

    // Stage 2: owner tag follows the RAM read latency so the response lines up with ram_data_out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_owner_q <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_owner_q <= s1_owner_q;
        end
    end

    // Last delivered word per requester, presented while its strobe is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold0_q <= '0;
            hold1_q <= '0;
        end else begin
            if (m0_rsp_valid) begin
                hold0_q <= ram_data_out;
            end
            if (m1_rsp_valid) begin
                hold1_q <= ram_data_out;
            end
        end
    end

    assign m0_rsp_valid     = s2_valid_q && !s2_owner_q;
    assign m1_rsp_valid     = s2_valid_q &&  s2_owner_q;
    assign m0_data_out      = m0_rsp_valid ? ram_data_out : hold0_q;
    assign m1_data_out      = m1_rsp_valid ? ram_data_out : hold1_q;
    assign ram_write_enable = ram_we_q;
    assign ram_address      = ram_addr_q;
    assign ram_data_in      = ram_wdata_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter with a read-first RAM model
module tb_ram_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_valid, m0_ready, m0_rsp_valid;
    logic [AW-1:0] m0_address;
    logic [3:0]    m0_write_enable;
    logic [DW-1:0] m0_data_in, m0_data_out;
    logic          m1_valid, m1_ready, m1_rsp_valid;
    logic [AW-1:0] m1_address;
    logic [3:0]    m1_write_enable;
    logic [DW-1:0] m1_data_in, m1_data_out;
    logic [3:0]    ram_write_enable;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;

    logic [DW-1:0] mem [0:255];
    exp_t          sb[$];
    exp_t          mon_e;
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    logic [4:0]    exp_g1;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_address(m0_address),
        .m0_write_enable(m0_write_enable), .m0_data_in(m0_data_in),
        .m0_rsp_valid(m0_rsp_valid), .m0_data_out(m0_data_out),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_address(m1_address),
        .m1_write_enable(m1_write_enable), .m1_data_in(m1_data_in),
        .m1_rsp_valid(m1_rsp_valid), .m1_data_out(m1_data_out),
        .ram_write_enable(ram_write_enable), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Read-first RAM with one registered cycle of read latency.
    always @(posedge clk) begin
        ram_data_out <= mem[ram_address[7:0]];
        for (int c = 0; c < 4; c++) begin
            if (ram_write_enable[c]) mem[ram_address[7:0]][c*8 +: 8] <= ram_data_in[c*8 +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop the scoreboard whenever a response strobe is seen.
    always @(negedge clk) begin
        if (m0_rsp_valid === 1'b1 || m1_rsp_valid === 1'b1) begin
            check("rsp_onehot", {31'd0, m0_rsp_valid & m1_rsp_valid}, 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got m0=%0b m1=%0b at cycle %0d required none", m0_rsp_valid, m1_rsp_valid, cyc);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_owner", {31'd0, m1_rsp_valid}, mon_e.owner);
                check("rsp_data", m1_rsp_valid ? m1_data_out : m0_data_out, mon_e.data);
                check("rsp_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'h11223344;
        rst_n = 1'b0;
        m0_valid = 1'b1; m0_address = '0; m0_write_enable = '0; m0_data_in = '0;
        m1_valid = 1'b1; m1_address = '0; m1_write_enable = '0; m1_data_in = '0;

        // Reset state, ready held low under reset even with valid requests
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_m0_ready", m0_ready, 0);
        check("rst_m1_ready", m1_ready, 0);
        check("rst_ram_we", ram_write_enable, 0);
        check("rst_ram_addr", ram_address, 0);
        check("rst_ram_din", ram_data_in, 0);
        check("rst_m0_rsp", m0_rsp_valid, 0);
        check("rst_m0_dout", m0_data_out, 0);
        check("rst_m1_dout", m1_data_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0;
        step();

        // Single read from m0
        m0_valid = 1'b1; m0_address = 16'h0010; m0_write_enable = 4'b0000;
        @(negedge clk);
        check("t1_m0_ready", m0_ready, 1);
        check("t1_m1_ready", m1_ready, 0);
        sb.push_back('{0, 32'hDEADBEEF, cyc + 2});
        step();
        m0_valid = 1'b0;
        @(negedge clk);
        check("t1_ram_addr", ram_address, 32'h0010);
        check("t1_ram_we", ram_write_enable, 0);
        check("idle_m0_ready", m0_ready, 0);
        step();
        step();
        @(negedge clk);
        check("t1_hold_dout", m0_data_out, 32'hDEADBEEF);
        check("t1_rsp_low", m0_rsp_valid, 0);
        step();

        // m1 column write then immediate read of the same word
        m1_valid = 1'b1; m1_address = 16'h0020; m1_write_enable = 4'b0101; m1_data_in = 32'hAABBCCDD;
        @(negedge clk);
        check("t2_m1_ready_w", m1_ready, 1);
        check("t2_m0_ready", m0_ready, 0);
        sb.push_back('{1, 32'h11223344, cyc + 2});
        step();
        m1_write_enable = 4'b0000;
        @(negedge clk);
        check("t2_ram_we", ram_write_enable, 32'h5);
        check("t2_ram_din", ram_data_in, 32'hAABBCCDD);
        check("t2_m1_ready_r", m1_ready, 1);
        sb.push_back('{1, 32'h11BB33DD, cyc + 2});
        step();
        m1_valid = 1'b0;
        repeat (3) step();

        // Contention: both valid for 4 cycles, then m0 drops
`ifdef RAM_PORT_ARBITER_ROUND_ROBIN_EN
        exp_g1 = 5'b11010;
`else
        exp_g1 = 5'b10000;
`endif
        m0_valid = 1'b1; m0_address = 16'h0010; m0_write_enable = 4'b0000;
        m1_valid = 1'b1; m1_address = 16'h0020; m1_write_enable = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) m0_valid = 1'b0;
            @(negedge clk);
            check($sformatf("t3_m0_ready_%0d", i), m0_ready, !exp_g1[i]);
            check($sformatf("t3_m1_ready_%0d", i), m1_ready, exp_g1[i]);
            sb.push_back('{exp_g1[i] ? 1 : 0, exp_g1[i] ? 32'h11BB33DD : 32'hDEADBEEF, cyc + 2});
            step();
        end
        m1_valid = 1'b0;
        repeat (3) step();

        // Reset while a read is in flight: its response must never appear
        m0_valid = 1'b1; m0_address = 16'h0010;
        @(negedge clk);
        check("t4_m0_ready", m0_ready, 1);
        step();
        rst_n = 1'b0;
        @(negedge clk);
        check("t4_ready_in_rst", m0_ready, 0);
        step();
        rst_n = 1'b1; m0_valid = 1'b0;
        @(negedge clk);
        check("t4_ram_we", ram_write_enable, 0);
        check("t4_m0_rsp", m0_rsp_valid, 0);
        check("t4_m0_dout", m0_data_out, 0);
        step();
        m1_valid = 1'b1; m1_address = 16'h0020;
        @(negedge clk);
        check("t4_m1_ready", m1_ready, 1);
        sb.push_back('{1, 32'h11BB33DD, cyc + 2});
        step();
        m1_valid = 1'b0;
        repeat (4) step();

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_BITWIDTH, default 16, word address width of the shared RAM.
REQ-002 SHALL have parameter DATA_BITWIDTH, default 32, RAM word width.
REQ-003 SHALL have parameter DATA_COLUMN_BITWIDTH, default 8, width of one byte-enable column; DATA_BITWIDTH/DATA_COLUMN_BITWIDTH = 4.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port mX_valid  in  1  request valid from requester X (X = 0, 1).
REQ-007 SHALL have port mX_ready  out  1  request accepted this cycle when high together with mX_valid.
REQ-008 SHALL have port mX_address  in  ADDRESS_BITWIDTH  request word address.
REQ-009 SHALL have port mX_write_enable  in  4  per-column write enables; 0 = read.
REQ-010 SHALL have port mX_data_in  in  DATA_BITWIDTH  write data.
REQ-011 SHALL have port mX_rsp_valid  out  1  one-cycle response strobe for requester X.
REQ-012 SHALL have port mX_data_out  out  DATA_BITWIDTH  read data, valid when mX_rsp_valid is high.
REQ-013 SHALL have port ram_write_enable  out  4  to RAM port A write enable.
REQ-014 SHALL have port ram_address  out  ADDRESS_BITWIDTH  to RAM port A address.
REQ-015 SHALL have port ram_data_in  out  DATA_BITWIDTH  to RAM port A write data.
REQ-016 SHALL have port ram_data_out  in  DATA_BITWIDTH  from RAM port A read data, one registered cycle after address.

Function
REQ-017 SHALL accept at most one request per cycle; mX_ready is combinational from mX_valid and the priority state; at most one mX_ready high per cycle.
REQ-018 SHALL assert mX_ready only when mX_valid is high; with no valid request both ready are 0.
REQ-019 SHALL register the accepted request at the accept edge (cycle N) and drive ram_address/ram_write_enable/ram_data_in from those registers during cycle N+1.
REQ-020 SHALL drive ram_write_enable = 0 in any cycle with no registered request; ram_address and ram_data_in hold their last values.
REQ-021 SHALL carry an owner tag and a valid bit through a two-stage pipeline and pulse the owner's mX_rsp_valid for exactly one cycle in cycle N+2 with mX_data_out = ram_data_out; other requester's rsp_valid stays 0.
REQ-022 SHALL issue a response for writes too (acknowledge); mX_data_out then equals the RAM word before the write (read-first port behaviour).
REQ-023 SHALL sustain one accepted request per cycle with back-to-back responses, no bubbles.
REQ-024 SHALL guarantee a read accepted in cycle N+1 or later to the address written by a request accepted in cycle N returns the new data.
REQ-025 SHALL hold mX_data_out at its last value when mX_rsp_valid is low.

Reset
REQ-026 SHALL, while rst_n = 0 at a clock edge, clear both pipeline valid bits, mX_rsp_valid = 0, ram_write_enable = 0, mX_data_out = 0, ram_address = 0, ram_data_in = 0, priority pointer = requester 0.
REQ-027 SHALL drop in-flight requests on reset mid-operation: no response is produced for them after rst_n returns high; mX_ready = 0 while rst_n = 0.

Configuration
REQ-028 SHALL, with macro RAM_PORT_ARBITER_ROUND_ROBIN_EN defined, arbitrate round-robin: a one-bit pointer names the preferred requester, flips to the other requester after each grant to the preferred one; the sole valid requester always wins.
REQ-029 SHALL, without RAM_PORT_ARBITER_ROUND_ROBIN_EN, use fixed priority: requester 0 always wins when m0_valid is high; pointer logic absent.

Verification
REQ-030 SHALL test: m0 read addr 0x0010 (RAM holds 0xDEADBEEF), m1 idle -> m0_ready at N, ram_address = 0x0010 at N+1, m0_rsp_valid with m0_data_out = 0xDEADBEEF at N+2.
REQ-031 SHALL test: m1 write addr 0x0020 we = 4'b0101 data 0xAABBCCDD over 0x11223344, then m1 read 0x0020 next cycle -> read returns 0x11BB33DD, two consecutive m1_rsp_valid pulses.
REQ-032 SHALL test (ROUND_ROBIN_EN): both valid for 4 cycles -> grants m0, m1, m0, m1; responses in same order at N+2..N+5.
REQ-033 SHALL test (no ROUND_ROBIN_EN): both valid for 4 cycles -> m0_ready all 4 cycles, m1_ready 0; m1 granted the cycle m0_valid drops.
REQ-034 SHALL test: accept m0 read, assert rst_n = 0 at N+1 for one cycle -> no m0_rsp_valid ever; ram_write_enable = 0; next request after reset served normally.
